// File: rtl/seq_core_ctx_arbiter.sv
// seq_core_ctx_arbiter
// Round-robin controller that time-shares one latch-stripped sequential core
// among NREQ requesters. Each requester owns a private copy of the core state
// (its context). One evaluation is: restore the context, apply one input
// vector, then capture the next state and the core output.
// Flow per request: IDLE (grant/accept) -> EVAL (core evaluates) -> RESP.
module seq_core_ctx_arbiter #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 4,
  parameter int OUT_W = 1,
  parameter int ST_W  = 3,
  parameter logic [ST_W-1:0] ST_INIT = {ST_W{1'b1}},
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*IN_W-1:0]   req_data,
  input  logic [NREQ-1:0]        req_clear,
  input  logic                   flush_all,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [OUT_W-1:0]       rsp_data,
  output logic [IN_W-1:0]        core_in,
  output logic [ST_W-1:0]        core_state,
  input  logic [ST_W-1:0]        core_next,
  input  logic [OUT_W-1:0]       core_out,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_sel_id;
  logic                 r_sel_clr;
  logic [IN_W-1:0]      r_core_in;
  logic                 r_rsp_valid;
  logic [ID_W-1:0]      r_rsp_id;
  logic [OUT_W-1:0]     r_rsp_data;
  logic [ST_W-1:0]      r_ctx [NREQ];

  logic [IN_W-1:0]      w_req_lane [NREQ];
  logic [ID_W-1:0]      w_rot_idx  [NREQ];
  logic                 w_found;
  logic [ID_W-1:0]      w_gnt_id;
  logic                 w_accept;
  logic                 w_handshake;
  logic [ID_W:0]        w_ptr_sum;
  logic [ID_W-1:0]      w_ptr_inc;

  // Unpack the flat request bus into per-requester lanes, and compute the
  // search order ptr, ptr+1, ... wrapped modulo NREQ (works for any NREQ,
  // not only powers of two, since the wrap compares against NREQ itself).
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      logic [ID_W:0] w_sum;
      logic [ID_W:0] w_wrap;

      assign w_req_lane[gi] = req_data[gi*IN_W +: IN_W];
      assign w_sum          = {1'b0, r_ptr} + (ID_W+1)'(gi);
      assign w_wrap         = (w_sum >= (ID_W+1)'(NREQ)) ? (w_sum - (ID_W+1)'(NREQ)) : w_sum;
      assign w_rot_idx[gi]  = w_wrap[ID_W-1:0];
    end
  endgenerate

  // Rotating priority: offset 0 from ptr wins, so scan from the far end and
  // let nearer offsets overwrite the choice.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[w_rot_idx[k]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_rot_idx[k];
      end
    end
  end

  assign w_accept    = (r_state == IDLE) && w_found;
  assign w_handshake = (r_state == RESP) && rsp_ready;

  // Ready is one-hot on the granted requester, and only while idle.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_accept && (w_gnt_id == ID_W'(gi));
    end
  endgenerate

  // Pointer advances to the requester after the one just served.
  assign w_ptr_sum = {1'b0, r_sel_id} + (ID_W+1)'(1);
  assign w_ptr_inc = (w_ptr_sum >= (ID_W+1)'(NREQ)) ? '0 : w_ptr_sum[ID_W-1:0];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: EVAL always lasts one cycle; RESP waits for rsp_ready.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = EVAL;
      EVAL:    w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture on accept; the input vector is frozen here so later
  // changes to req_data cannot disturb the evaluation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_core_in <= '0;
      r_sel_id  <= '0;
      r_sel_clr <= 1'b0;
    end else if (w_accept) begin
      r_core_in <= w_req_lane[w_gnt_id];
      r_sel_id  <= w_gnt_id;
      r_sel_clr <= req_clear[w_gnt_id];
    end
  end

  // Response register and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_ptr       <= '0;
    end else begin
      if (r_state == EVAL) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_sel_id;
        r_rsp_data  <= core_out;
      end else if (w_handshake) begin
        r_rsp_valid <= 1'b0;
        r_ptr       <= w_ptr_inc;
      end
    end
  end

  // Context storage. A flush overrides the evaluation write-back in the same
  // cycle, so a flushed context always restarts from ST_INIT.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ctx
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_ctx[gi] <= ST_INIT;
        end else if (flush_all) begin
          r_ctx[gi] <= ST_INIT;
        end else if ((r_state == EVAL) && (r_sel_id == ID_W'(gi))) begin
          r_ctx[gi] <= core_next;
        end
      end
    end
  endgenerate

  assign core_in    = r_core_in;
  assign core_state = r_sel_clr ? ST_INIT : r_ctx[r_sel_id];
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_seq_core_ctx_arbiter.sv
// Directed bench for seq_core_ctx_arbiter with a behavioural core
// (next = state ^ in[ST_W-1:0], out = &state) and a response scoreboard.
module tb_seq_core_ctx_arbiter;
  localparam int NREQ  = 4;
  localparam int IN_W  = 4;
  localparam int OUT_W = 1;
  localparam int ST_W  = 3;
  localparam int ID_W  = 2;
  localparam logic [ST_W-1:0] INIT = 3'b111;

  logic                 clock;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_clear;
  logic                 flush_all;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic [IN_W-1:0]      core_in;
  logic [ST_W-1:0]      core_state;
  logic [ST_W-1:0]      core_next;
  logic [OUT_W-1:0]     core_out;
  logic                 busy;

  typedef struct {
    int               id;
    logic [OUT_W-1:0] data;
  } exp_t;

  exp_t            q[$];
  int              checks   = 0;
  int              failures = 0;
  int              m_ptr    = 0;
  logic [ST_W-1:0] m_ctx [NREQ];

  int              g;
  logic [ST_W-1:0] pre;
  logic [IN_W-1:0] dv;
  exp_t            e;

  seq_core_ctx_arbiter #(
    .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .ST_W(ST_W), .ST_INIT(INIT), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_clear(req_clear),
    .flush_all(flush_all),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .core_in(core_in), .core_state(core_state), .core_next(core_next), .core_out(core_out),
    .busy(busy)
  );

  // Behavioural stand-in for the mapped core.
  assign core_next = core_state ^ core_in[ST_W-1:0];
  assign core_out  = &core_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Reference round-robin choice from the bench's own pointer.
  function automatic int rr(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic pop_chk(input string tag);
    exp_t x;
    chk({tag, "_q"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      x = q.pop_front();
      chk({tag, "_id"}, 32'(rsp_id), 32'(x.id));
      chk({tag, "_data"}, 32'(rsp_data), 32'(x.data));
      m_ptr = (x.id + 1) % NREQ;
      $display("rsp id=%0d data=%0d exp_id=%0d exp_data=%0d", rsp_id, rsp_data, x.id, x.data);
    end
  endtask

  // One request from a single requester, checked cycle by cycle.
  // Entered and left just after a falling edge with the DUT idle.
  task automatic single(input string tag, input int i, input logic [IN_W-1:0] d,
                        input logic clr, input int stall, input logic flush_eval);
    logic [ST_W-1:0] p;
    exp_t x;
    req_valid = '0; req_valid[i] = 1'b1;
    req_data  = '0; req_data[i*IN_W +: IN_W] = d;
    req_clear = '0; req_clear[i] = clr;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(oh(rr(req_valid))));
    p = clr ? INIT : m_ctx[i];
    x.id = i; x.data = &p;
    q.push_back(x);
    m_ctx[i] = p ^ d[ST_W-1:0];
    @(posedge clock);
    @(negedge clock);
    req_valid = '0; req_clear = '0; req_data = '1;
    if (flush_eval) flush_all = 1'b1;
    #1;
    chk({tag, "_eval_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_eval_busy"}, 32'(busy), 32'd1);
    chk({tag, "_eval_rspv"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_core_in"}, 32'(core_in), 32'(d));
    chk({tag, "_core_state"}, 32'(core_state), 32'(p));
    @(negedge clock);
    flush_all = 1'b0;
    if (flush_eval) for (int k = 0; k < NREQ; k++) m_ctx[k] = INIT;
    #1;
    chk({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    pop_chk(tag);
    for (int s = 0; s < stall; s++) begin
      req_valid = '1;
      @(negedge clock);
      #1;
      chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_id"}, 32'(rsp_id), 32'(x.id));
      chk({tag, "_hold_data"}, 32'(rsp_data), 32'(x.data));
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_done_v"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) m_ctx[k] = INIT;
    reset_n = 1'b0; req_valid = '0; req_data = '0; req_clear = '0;
    flush_all = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_in", 32'(core_in), 32'd0);
    chk("rst_core_state", 32'(core_state), 32'(INIT));
    reset_n = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Basic step and context persistence on requester 0.
    single("s1", 0, 4'h1, 1'b0, 0, 1'b0);
    single("s2", 0, 4'h1, 1'b0, 0, 1'b0);

    // Round robin with all requesters valid and response always accepted.
    req_valid = '1; req_clear = '0; rsp_ready = 1'b1;
    req_data  = {4'h3, 4'h5, 4'h2, 4'h6};
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("rr_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (c % 3 == 0) begin
        g = rr(req_valid);
        chk("rr_grant", 32'(req_ready), 32'(oh(g)));
        $display("grant exp=%0d ready=%b", g, req_ready);
        pre = m_ctx[g];
        dv = req_data[g*IN_W +: IN_W];
        e.id = g; e.data = &pre;
        q.push_back(e);
        m_ctx[g] = pre ^ dv[ST_W-1:0];
      end else begin
        chk("rr_gap_ready", 32'(req_ready), 32'd0);
      end
      chk("rr_rspv", 32'(rsp_valid), 32'(c % 3 == 2));
      if (c % 3 == 2) pop_chk("rr_rsp");
      if (c == 14) req_valid = '0;
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    #1;
    chk("rr_end_busy", 32'(busy), 32'd0);

    // Backpressure held for five cycles.
    single("s4", 2, 4'h6, 1'b0, 5, 1'b0);

    // Clear: drive ctx1 to zero, then evaluate it from the initial value.
    single("s5a", 1, IN_W'(m_ctx[1]), 1'b0, 0, 1'b0);
    single("s5b", 1, 4'h5, 1'b1, 0, 1'b0);
    single("s5c", 1, 4'h0, 1'b0, 0, 1'b0);

    // Flush coincident with the EVAL write-back, then read every context.
    single("s6f", 2, 4'h3, 1'b0, 0, 1'b1);
    for (int k = 0; k < NREQ; k++) single("s6chk", k, 4'h0, 1'b0, 0, 1'b0);

    // Asynchronous reset while a response is pending.
    single("s6pre", 3, 4'h6, 1'b0, 0, 1'b0);
    req_valid = 4'b0100; req_data = '0; req_data[2*IN_W +: IN_W] = 4'h5;
    #1;
    chk("s6r_grant", 32'(req_ready), 32'(oh(rr(req_valid))));
    @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    #1;
    chk("s6r_rspv", 32'(rsp_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6r_async_rspv", 32'(rsp_valid), 32'd0);
    chk("s6r_async_busy", 32'(busy), 32'd0);
    chk("s6r_async_state", 32'(core_state), 32'(INIT));
    @(negedge clock);
    reset_n = 1'b1;
    m_ptr = 0;
    for (int k = 0; k < NREQ; k++) m_ctx[k] = INIT;
    #1;
    req_valid = '1;
    #1;
    chk("s6r_ptr0", 32'(req_ready), 32'd1);
    req_valid = '0;
    @(negedge clock);
    single("s6post", 3, 4'h2, 1'b0, 0, 1'b0);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
